// File: rtl/pokey_sio_uart.sv
`timescale 1ns/1ps
// pokey_sio_uart: 8N1 serial engine behind POKEY SEROUT/SERIN.
// Transmits bytes from the serout handshake and presents received bytes on
// the serin handshake. TX and RX share only the clock and reset.
module pokey_sio_uart #(
  parameter int DIV   = 64,
  parameter int DIV_W = 16
) (
  input  logic       clk_i,
  input  logic       rst,
  input  logic [7:0] tx_dat_i,
  input  logic       tx_rdy_i,
  output logic       tx_ack_o,
  output logic [7:0] rx_dat_o,
  output logic       rx_rdy_o,
  input  logic       rx_ack_i,
  output logic       sio_txd_o,
  input  logic       sio_rxd_i,
  output logic       tx_busy_o,
  output logic       rx_overrun_o,
  output logic       rx_frame_err_o
);

  localparam logic [DIV_W-1:0] BIT_END  = DIV_W'(DIV - 1);
  localparam logic [DIV_W-1:0] HALF_END = DIV_W'(DIV / 2 - 1);

  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_e;
  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_BRK} rx_state_e;

  tx_state_e        tx_state_q, tx_state_d;
  logic [DIV_W-1:0] tx_cnt_q, tx_cnt_d;
  logic [2:0]       tx_idx_q, tx_idx_d;
  logic [7:0]       tx_shift_q, tx_shift_d;
  logic             tx_ack_q, tx_ack_d;
  logic             txd_q, txd_d;

  rx_state_e        rx_state_q, rx_state_d;
  logic [DIV_W-1:0] rx_cnt_q, rx_cnt_d;
  logic [2:0]       rx_idx_q, rx_idx_d;
  logic [7:0]       rx_shift_q, rx_shift_d;
  logic [7:0]       rx_dat_q, rx_dat_d;
  logic             rx_rdy_q, rx_rdy_d;
  logic             rx_ack_prev_q, rx_ack_prev_d;
  logic             rx_ovr_q, rx_ovr_d;
  logic             rx_ferr_q, rx_ferr_d;
  logic             rx_sync1_q, rx_sync1_d;
  logic             rx_sync2_q, rx_sync2_d;

  logic             rxd;
  logic             ack_rise;

  assign rxd      = rx_sync2_q;
  assign ack_rise = rx_ack_i & ~rx_ack_prev_q;

  // Transmitter: accept a byte in idle, then shift start/data/stop, DIV cycles each
  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q;
    tx_idx_d   = tx_idx_q;
    tx_shift_d = tx_shift_q;
    tx_ack_d   = 1'b0;
    txd_d      = txd_q;
    case (tx_state_q)
      TX_IDLE: begin
        tx_cnt_d = '0;
        txd_d    = 1'b1;
        if (tx_rdy_i) begin
          tx_shift_d = tx_dat_i;
          tx_ack_d   = 1'b1;
          txd_d      = 1'b0;
          tx_idx_d   = 3'd0;
          tx_state_d = TX_START;
        end
      end
      TX_START: begin
        if (tx_cnt_q == BIT_END) begin
          tx_cnt_d   = '0;
          txd_d      = tx_shift_q[0];
          tx_idx_d   = 3'd0;
          tx_state_d = TX_DATA;
        end else begin
          tx_cnt_d = tx_cnt_q + 1'b1;
        end
      end
      TX_DATA: begin
        if (tx_cnt_q == BIT_END) begin
          tx_cnt_d = '0;
          if (tx_idx_q == 3'd7) begin
            txd_d      = 1'b1;
            tx_state_d = TX_STOP;
          end else begin
            tx_shift_d = {1'b0, tx_shift_q[7:1]};
            txd_d      = tx_shift_q[1];
            tx_idx_d   = tx_idx_q + 3'd1;
          end
        end else begin
          tx_cnt_d = tx_cnt_q + 1'b1;
        end
      end
      TX_STOP: begin
        if (tx_cnt_q == BIT_END) begin
          tx_cnt_d   = '0;
          tx_state_d = TX_IDLE;
        end else begin
          tx_cnt_d = tx_cnt_q + 1'b1;
        end
      end
      default: begin
        tx_state_d = TX_IDLE;
        txd_d      = 1'b1;
      end
    endcase
  end

  // Receiver: synchronise the line, centre-sample each bit, hand bytes to POKEY
  always_comb begin
    rx_sync1_d    = sio_rxd_i;
    rx_sync2_d    = rx_sync1_q;
    rx_ack_prev_d = rx_ack_i;
    rx_state_d    = rx_state_q;
    rx_cnt_d      = rx_cnt_q;
    rx_idx_d      = rx_idx_q;
    rx_shift_d    = rx_shift_q;
    rx_dat_d      = rx_dat_q;
    rx_rdy_d      = rx_rdy_q;
    rx_ovr_d      = 1'b0;
    rx_ferr_d     = 1'b0;
    if (ack_rise && rx_rdy_q) begin
      rx_rdy_d = 1'b0;
    end
    case (rx_state_q)
      RX_IDLE: begin
        rx_cnt_d = '0;
        if (!rxd) begin
          rx_state_d = RX_START;
        end
      end
      RX_START: begin
        if (rx_cnt_q == HALF_END) begin
          rx_cnt_d   = '0;
          rx_idx_d   = 3'd0;
          rx_state_d = rxd ? RX_IDLE : RX_DATA;
        end else begin
          rx_cnt_d = rx_cnt_q + 1'b1;
        end
      end
      RX_DATA: begin
        if (rx_cnt_q == BIT_END) begin
          rx_cnt_d   = '0;
          rx_shift_d = {rxd, rx_shift_q[7:1]};
          if (rx_idx_q == 3'd7) begin
            rx_state_d = RX_STOP;
          end else begin
            rx_idx_d = rx_idx_q + 3'd1;
          end
        end else begin
          rx_cnt_d = rx_cnt_q + 1'b1;
        end
      end
      RX_STOP: begin
        if (rx_cnt_q == BIT_END) begin
          rx_cnt_d = '0;
          if (rxd) begin
            if (rx_rdy_q) begin
              rx_ovr_d = 1'b1;
            end else begin
              rx_dat_d = rx_shift_q;
              rx_rdy_d = 1'b1;
            end
            rx_state_d = RX_IDLE;
          end else begin
            rx_ferr_d  = 1'b1;
            rx_state_d = RX_BRK;
          end
        end else begin
          rx_cnt_d = rx_cnt_q + 1'b1;
        end
      end
      RX_BRK: begin
        rx_cnt_d = '0;
        if (rxd) begin
          rx_state_d = RX_IDLE;
        end
      end
      default: rx_state_d = RX_IDLE;
    endcase
  end

  // State registers for both directions; reset wins over everything
  always_ff @(posedge clk_i) begin
    if (rst) begin
      tx_state_q    <= TX_IDLE;
      tx_cnt_q      <= '0;
      tx_idx_q      <= 3'd0;
      tx_shift_q    <= 8'h00;
      tx_ack_q      <= 1'b0;
      txd_q         <= 1'b1;
      rx_state_q    <= RX_IDLE;
      rx_cnt_q      <= '0;
      rx_idx_q      <= 3'd0;
      rx_shift_q    <= 8'h00;
      rx_dat_q      <= 8'h00;
      rx_rdy_q      <= 1'b0;
      rx_ack_prev_q <= 1'b0;
      rx_ovr_q      <= 1'b0;
      rx_ferr_q     <= 1'b0;
      rx_sync1_q    <= 1'b1;
      rx_sync2_q    <= 1'b1;
    end else begin
      tx_state_q    <= tx_state_d;
      tx_cnt_q      <= tx_cnt_d;
      tx_idx_q      <= tx_idx_d;
      tx_shift_q    <= tx_shift_d;
      tx_ack_q      <= tx_ack_d;
      txd_q         <= txd_d;
      rx_state_q    <= rx_state_d;
      rx_cnt_q      <= rx_cnt_d;
      rx_idx_q      <= rx_idx_d;
      rx_shift_q    <= rx_shift_d;
      rx_dat_q      <= rx_dat_d;
      rx_rdy_q      <= rx_rdy_d;
      rx_ack_prev_q <= rx_ack_prev_d;
      rx_ovr_q      <= rx_ovr_d;
      rx_ferr_q     <= rx_ferr_d;
      rx_sync1_q    <= rx_sync1_d;
      rx_sync2_q    <= rx_sync2_d;
    end
  end

  assign tx_ack_o       = tx_ack_q;
  assign sio_txd_o      = txd_q;
  assign tx_busy_o      = (tx_state_q != TX_IDLE);
  assign rx_dat_o       = rx_dat_q;
  assign rx_rdy_o       = rx_rdy_q;
  assign rx_overrun_o   = rx_ovr_q;
  assign rx_frame_err_o = rx_ferr_q;

endmodule

// File: tb/tb_pokey_sio_uart.sv
`timescale 1ns/1ps
// tb_pokey_sio_uart: table-driven TX waveform checks, hand-written corner
// sequences, and random loopback traffic against a byte-level model.
module tb_pokey_sio_uart;

  localparam int DIV = 8;
  localparam int FRAME = 10 * DIV;

  logic       clk_i;
  logic       rst;
  logic [7:0] tx_dat_i;
  logic       tx_rdy_i;
  logic       tx_ack_o;
  logic [7:0] rx_dat_o;
  logic       rx_rdy_o;
  logic       rx_ack_i;
  logic       sio_txd_o;
  logic       sio_rxd_i;
  logic       tx_busy_o;
  logic       rx_overrun_o;
  logic       rx_frame_err_o;

  logic       loopback;
  logic       bench_rxd;

  int total;
  int bad;
  int ack_cnt;
  int ovr_cnt;
  int ferr_cnt;

  typedef struct {
    logic [7:0] dat;
    logic [9:0] levels;
  } tx_vec_t;

  tx_vec_t vecs[5];

  pokey_sio_uart #(.DIV(DIV), .DIV_W(16)) dut (
    .clk_i          (clk_i),
    .rst            (rst),
    .tx_dat_i       (tx_dat_i),
    .tx_rdy_i       (tx_rdy_i),
    .tx_ack_o       (tx_ack_o),
    .rx_dat_o       (rx_dat_o),
    .rx_rdy_o       (rx_rdy_o),
    .rx_ack_i       (rx_ack_i),
    .sio_txd_o      (sio_txd_o),
    .sio_rxd_i      (sio_rxd_i),
    .tx_busy_o      (tx_busy_o),
    .rx_overrun_o   (rx_overrun_o),
    .rx_frame_err_o (rx_frame_err_o)
  );

  assign sio_rxd_i = loopback ? sio_txd_o : bench_rxd;

  // 10 ns clock
  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  // Count single-cycle pulses away from the active edge
  initial begin
    ack_cnt  = 0;
    ovr_cnt  = 0;
    ferr_cnt = 0;
  end
  always @(negedge clk_i) begin
    if (tx_ack_o)       ack_cnt  = ack_cnt + 1;
    if (rx_overrun_o)   ovr_cnt  = ovr_cnt + 1;
    if (rx_frame_err_o) ferr_cnt = ferr_cnt + 1;
  end

  // Hard stop in case something hangs despite the bounded waits
  initial begin
    #5000000;
    $display("[TB] FAIL watchdog: got timeout want completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
    total = total + 1;
    if (actual !== expected) begin
      bad = bad + 1;
      $display("[TB] FAIL %s: got %0h want %0h", name, actual, expected);
    end
  endtask

  // Send one table entry with loopback off and check edges of every bit cell
  task automatic apply_stimulus(input tx_vec_t v, input int idx);
    int busy;
    int ack0;
    ack0     = ack_cnt;
    busy     = 0;
    tx_dat_i = v.dat;
    tx_rdy_i = 1'b1;
    tick();
    tx_rdy_i = 1'b0;
    for (int k = 0; k < FRAME; k++) begin
      if ((k % DIV) == 0 || (k % DIV) == DIV - 1)
        check_output($sformatf("txd_v%0d_k%0d", idx, k), 32'(sio_txd_o), 32'(v.levels[k / DIV]));
      if (k < 2)
        check_output($sformatf("tx_ack_v%0d_k%0d", idx, k), 32'(tx_ack_o), (k == 0) ? 32'd1 : 32'd0);
      if (tx_busy_o) busy++;
      tick();
    end
    check_output($sformatf("busy_end_v%0d", idx), 32'(tx_busy_o), 32'd0);
    check_output($sformatf("txd_end_v%0d", idx), 32'(sio_txd_o), 32'd1);
    check_output($sformatf("busy_cycles_v%0d", idx), 32'(busy), 32'(FRAME));
    check_output($sformatf("ack_pulses_v%0d", idx), 32'(ack_cnt - ack0), 32'd1);
  endtask

  // Send a byte and reconstruct it from bit-centre samples of the line
  task automatic send_lb(input logic [7:0] b, output logic [7:0] dec, output logic st, output logic sp);
    logic [9:0] samp;
    samp     = '0;
    tx_dat_i = b;
    tx_rdy_i = 1'b1;
    tick();
    tx_rdy_i = 1'b0;
    for (int k = 0; k < FRAME; k++) begin
      if ((k % DIV) == DIV / 2) samp[k / DIV] = sio_txd_o;
      tick();
    end
    dec = samp[8:1];
    st  = samp[0];
    sp  = samp[9];
  endtask

  // Drive a serial frame directly on the receive line
  task automatic drive_serial(input logic [7:0] b, input logic stop_bit);
    logic [9:0] bits;
    bits = {stop_bit, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      bench_rxd = bits[i];
      ticks(DIV);
    end
  endtask

  task automatic ack_pulse(input string name);
    rx_ack_i = 1'b1;
    tick();
    check_output({name, "_rdy_after_rise"}, 32'(rx_rdy_o), 32'd0);
    tick();
    rx_ack_i = 1'b0;
    tick();
    check_output({name, "_rdy_after_ack"}, 32'(rx_rdy_o), 32'd0);
  endtask

  task automatic wait_busy_low(input string name, input int budget);
    int n;
    n = 0;
    while (tx_busy_o && n < budget) begin
      tick();
      n++;
    end
    check_output({name, "_busy_timeout"}, 32'(tx_busy_o), 32'd0);
  endtask

  initial begin
    logic [7:0] dec;
    logic       st;
    logic       sp;
    logic [7:0] b;
    logic [7:0] m_dat;
    logic       m_rdy;
    int         m_ovr;
    int         base;
    int         fbase;

    total     = 0;
    bad       = 0;
    rst       = 1'b1;
    tx_dat_i  = 8'h5A;
    tx_rdy_i  = 1'b1;
    rx_ack_i  = 1'b0;
    loopback  = 1'b0;
    bench_rxd = 1'b1;

    vecs[0] = '{8'hA5, 10'b1101001010};
    vecs[1] = '{8'h00, 10'b1000000000};
    vecs[2] = '{8'hFF, 10'b1111111110};
    vecs[3] = '{8'h3C, 10'b1001111000};
    vecs[4] = '{8'h01, 10'b1000000010};

    // Reset with a pending byte: reset must win
    ticks(3);
    check_output("rst_txd", 32'(sio_txd_o), 32'd1);
    check_output("rst_ack", 32'(tx_ack_o), 32'd0);
    check_output("rst_busy", 32'(tx_busy_o), 32'd0);
    check_output("rst_rdy", 32'(rx_rdy_o), 32'd0);
    check_output("rst_dat", 32'(rx_dat_o), 32'h00);
    check_output("rst_ovr", 32'(rx_overrun_o), 32'd0);
    check_output("rst_ferr", 32'(rx_frame_err_o), 32'd0);
    rst      = 1'b0;
    tx_rdy_i = 1'b0;
    tick();

    // Table-driven TX waveforms
    for (int i = 0; i < 5; i++) apply_stimulus(vecs[i], i);

    // Loopback 3C, then a 2-cycle ack
    loopback = 1'b1;
    send_lb(8'h3C, dec, st, sp);
    ticks(2);
    check_output("lb_rdy", 32'(rx_rdy_o), 32'd1);
    check_output("lb_dat", 32'(rx_dat_o), 32'h3C);
    ack_pulse("lb3c");

    // Back-to-back 11 then 22 without ack: overrun on the second
    base     = ovr_cnt;
    fbase    = ack_cnt;
    tx_dat_i = 8'h11;
    tx_rdy_i = 1'b1;
    tick();
    tx_dat_i = 8'h22;
    ticks(FRAME);
    check_output("b2b_gap_txd", 32'(sio_txd_o), 32'd1);
    check_output("b2b_gap_busy", 32'(tx_busy_o), 32'd0);
    check_output("b2b_gap_ack", 32'(tx_ack_o), 32'd0);
    tick();
    check_output("b2b_second_ack", 32'(tx_ack_o), 32'd1);
    check_output("b2b_second_txd", 32'(sio_txd_o), 32'd0);
    tx_rdy_i = 1'b0;
    ticks(FRAME + 3);
    check_output("ovr_dat", 32'(rx_dat_o), 32'h11);
    check_output("ovr_rdy", 32'(rx_rdy_o), 32'd1);
    check_output("ovr_pulses", 32'(ovr_cnt - base), 32'd1);
    check_output("b2b_acks", 32'(ack_cnt - fbase), 32'd2);
    ack_pulse("ovr");

    // Ack held high as a level across an arrival must not consume the byte
    rx_ack_i = 1'b1;
    tick();
    send_lb(8'h77, dec, st, sp);
    ticks(2);
    check_output("lvl_rdy", 32'(rx_rdy_o), 32'd1);
    check_output("lvl_dat", 32'(rx_dat_o), 32'h77);
    rx_ack_i = 1'b0;
    tick();
    check_output("lvl_rdy_after_drop", 32'(rx_rdy_o), 32'd1);
    ack_pulse("lvl");

    // Framing error then line held low, then a good 5A frame
    loopback = 1'b0;
    fbase    = ferr_cnt;
    base     = ovr_cnt;
    drive_serial(8'h96, 1'b0);
    bench_rxd = 1'b0;
    ticks(40);
    bench_rxd = 1'b1;
    ticks(16);
    check_output("ferr_pulses", 32'(ferr_cnt - fbase), 32'd1);
    check_output("ferr_rdy", 32'(rx_rdy_o), 32'd0);
    drive_serial(8'h5A, 1'b1);
    ticks(8);
    check_output("after_ferr_rdy", 32'(rx_rdy_o), 32'd1);
    check_output("after_ferr_dat", 32'(rx_dat_o), 32'h5A);
    check_output("after_ferr_pulses", 32'(ferr_cnt - fbase), 32'd1);
    ack_pulse("ferr");

    // Two-cycle glitch must produce nothing
    bench_rxd = 1'b0;
    ticks(2);
    bench_rxd = 1'b1;
    ticks(3 * FRAME / 2);
    check_output("glitch_rdy", 32'(rx_rdy_o), 32'd0);
    check_output("glitch_dat", 32'(rx_dat_o), 32'h5A);
    check_output("glitch_ferr", 32'(ferr_cnt - fbase), 32'd0 + 32'd1);
    check_output("glitch_ovr", 32'(ovr_cnt - base), 32'd0);

    // Reset in the middle of data bit 4
    tx_dat_i = 8'h00;
    tx_rdy_i = 1'b1;
    tick();
    tx_rdy_i = 1'b0;
    ticks(5 * DIV + 2);
    check_output("midrst_pre_txd", 32'(sio_txd_o), 32'd0);
    check_output("midrst_pre_busy", 32'(tx_busy_o), 32'd1);
    rst = 1'b1;
    tick();
    check_output("midrst_txd", 32'(sio_txd_o), 32'd1);
    check_output("midrst_busy", 32'(tx_busy_o), 32'd0);
    check_output("midrst_dat", 32'(rx_dat_o), 32'h00);
    rst      = 1'b0;
    tx_dat_i = 8'hC3;
    tx_rdy_i = 1'b1;
    tick();
    check_output("postrst_ack", 32'(tx_ack_o), 32'd1);
    check_output("postrst_txd", 32'(sio_txd_o), 32'd0);
    tx_rdy_i = 1'b0;
    wait_busy_low("postrst", 4 * FRAME);
    tick();

    // Random loopback traffic against a byte-level handshake model
    loopback = 1'b1;
    m_dat    = 8'h00;
    m_rdy    = 1'b0;
    m_ovr    = 0;
    base     = ovr_cnt;
    for (int i = 0; i < 12; i++) begin
      b = 8'($urandom_range(0, 255));
      send_lb(b, dec, st, sp);
      ticks(3);
      check_output($sformatf("rnd%0d_line_byte", i), 32'(dec), 32'(b));
      check_output($sformatf("rnd%0d_line_start", i), 32'(st), 32'd0);
      check_output($sformatf("rnd%0d_line_stop", i), 32'(sp), 32'd1);
      if (!m_rdy) begin
        m_dat = b;
        m_rdy = 1'b1;
      end else begin
        m_ovr++;
      end
      check_output($sformatf("rnd%0d_rdy", i), 32'(rx_rdy_o), 32'(m_rdy));
      check_output($sformatf("rnd%0d_dat", i), 32'(rx_dat_o), 32'(m_dat));
      check_output($sformatf("rnd%0d_ovr", i), 32'(ovr_cnt - base), 32'(m_ovr));
      if ($urandom_range(0, 1) == 1) begin
        ack_pulse($sformatf("rnd%0d", i));
        m_rdy = 1'b0;
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
